// File: rtl/fifo_sync_reader.sv
// fifo_sync_reader: read-side master for a fifo_sync instance.
// Pops words whenever the FIFO holds data and the output stage has room,
// absorbs the FIFO's one-cycle registered read latency, and re-presents the
// words on a valid/ready stream through a 2-entry skid buffer.
module fifo_sync_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    // Skid-buffer occupancy; the encoding equals the number of held words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ_q, occ_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

    logic                  pop;
    logic                  capture;
    logic [2:0]            committed;

    // Handshake decode and pop-request gating: a new read may only be issued
    // when the words already held or in flight, less the one leaving this
    // cycle, leave a free slot in the skid buffer.
    always_comb begin
        pop        = (occ_q != EMPTY) && m_ready;
        capture    = pending_q && !flush;
        committed  = {1'b0, occ_q} + {2'b0, pending_q} - {2'b0, pop};
        fifo_rd_en = !rst && !flush && !fifo_empty && (committed < 3'd2);
        fifo_cs    = !rst;
        m_valid    = (occ_q != EMPTY);
        m_data     = head_q;
        rd_count   = rd_count_q;
    end

    // Occupancy FSM next-state and buffer datapath: captures land behind any
    // existing entry, pops shift the tail forward, flush empties the buffer.
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pending_d  = fifo_rd_en;
        rd_count_d = rd_count_q + CNT_WIDTH'(pop);

        if (flush) begin
            occ_d = EMPTY;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (capture) begin
                        head_d = fifo_data_out;
                        occ_d  = ONE;
                    end
                end
                ONE: begin
                    if (capture && pop) begin
                        head_d = fifo_data_out;
                    end else if (capture) begin
                        tail_d = fifo_data_out;
                        occ_d  = TWO;
                    end else if (pop) begin
                        occ_d  = EMPTY;
                    end
                end
                TWO: begin
                    if (capture && pop) begin
                        head_d = tail_q;
                        tail_d = fifo_data_out;
                    end else if (pop) begin
                        head_d = tail_q;
                        occ_d  = ONE;
                    end
                end
                default: begin
                    occ_d = EMPTY;
                end
            endcase
        end
    end

    // State register; reset clears control, the head word and the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            pending_q  <= 1'b0;
            head_q     <= '0;
            rd_count_q <= '0;
        end else begin
            occ_q      <= occ_d;
            pending_q  <= pending_d;
            head_q     <= head_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Second buffer slot carries only data and needs no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    // Held words plus the word in flight never exceed the buffer depth.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, occ_q} + {2'b0, pending_q}) <= 3'd2));

endmodule

// File: tb/tb_fifo_sync_reader.sv
// Testbench for fifo_sync_reader: behavioural fifo_sync model on the read
// side, a queue of words popped from it as the expected stream, and a
// monitor that compares every delivered word and the delivered-word count.
module tb_fifo_sync_reader;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_cs;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          flush;
    logic [CW-1:0] rd_count;

    fifo_sync_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .flush(flush), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int comps = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] fifo_q[$];   // words stored in the modelled fifo_sync
    logic [DW-1:0] exp_q[$];    // words popped from the FIFO, not yet delivered
    int  model_cnt = 0;
    int  rd_cnt = 0, mv_cnt = 0;
    int  rd_first = -1, mv_first = -1, mv_last = -1;
    bit  armed = 0;
    bit  prev_hold = 0;
    logic [DW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        comps++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // fifo_sync read port model plus reference update of the expected stream
    initial begin
        logic [DW-1:0] nxt;
        bit            popped;
        forever begin
            @(negedge clk);
            #1;
            popped = 0;
            if (rst || flush) exp_q.delete();
            if (fifo_rd_en === 1'b1) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = cyc;
                chk("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
                if (!fifo_empty && fifo_q.size() > 0) begin
                    nxt = fifo_q.pop_front();
                    exp_q.push_back(nxt);
                    popped = 1;
                end
            end
            @(posedge clk);
            #1;
            fifo_data_out = popped ? nxt : DW'($urandom);
            fifo_empty    = (fifo_q.size() == 0);
        end
    end

    // Monitor: compares delivered words and the counter against the model
    always @(negedge clk) begin
        chk("fifo_cs", {63'd0, fifo_cs}, {63'd0, !rst});
        if (rst) chk("rd_en_in_reset", {63'd0, fifo_rd_en}, 64'd0);
        if (armed) chk("rd_count", {60'd0, rd_count}, 64'(model_cnt % (1 << CW)));
        if (armed && prev_hold) begin
            chk("hold_valid", {63'd0, m_valid}, 64'd1);
            chk("hold_data", {32'd0, m_data}, {32'd0, prev_data});
        end
        if (armed && m_valid === 1'b1) begin
            mv_cnt++;
            if (mv_first < 0) mv_first = cyc;
            mv_last = cyc;
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("m_data", {32'd0, m_data}, {32'd0, exp_q.pop_front()});
                end
                model_cnt++;
            end
        end
        prev_hold = m_valid && !m_ready && !flush && !rst;
        prev_data = m_data;
        if (rst) begin
            model_cnt = 0;
            armed = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic reset_marks();
        rd_cnt = 0; mv_cnt = 0; rd_first = -1; mv_first = -1; mv_last = -1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (n < 200 && !(fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid)) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({nm, "_drain_timeout"}, 64'(n < 200), 64'd1);
        chk({nm, "_lost_words"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_data_out = '0; m_ready = 1'b0; flush = 1'b0;
        // reset then idle
        repeat (2) begin
            tick();
            chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
            chk("rst_m_data", {32'd0, m_data}, 64'd0);
            chk("rst_rd_count", {60'd0, rd_count}, 64'd0);
            chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
            chk("rst_cs", {63'd0, fifo_cs}, 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("cs_after_rst", {63'd0, fifo_cs}, 64'd1);
        repeat (3) tick();
        chk("idle_m_valid", {63'd0, m_valid}, 64'd0);

        // single word
        reset_marks();
        m_ready = 1'b1;
        wr(100);
        repeat (8) tick();
        chk("single_rd_pulses", 64'(rd_cnt), 64'd1);
        chk("single_valid_cycles", 64'(mv_cnt), 64'd1);
        chk("single_latency", 64'(mv_first - rd_first), 64'd2);
        chk("single_rd_count", {60'd0, rd_count}, 64'd1);

        // streaming
        reset_marks();
        for (int i = 0; i < 8; i++) begin
            wr(DW'(1) << i);
            tick();
        end
        repeat (6) tick();
        chk("stream_rd_pulses", 64'(rd_cnt), 64'd8);
        chk("stream_valid_cycles", 64'(mv_cnt), 64'd8);
        chk("stream_contiguous", 64'(mv_last - mv_first), 64'd7);
        chk("stream_rd_count", {60'd0, rd_count}, 64'd9);

        // back-pressure
        reset_marks();
        m_ready = 1'b0;
        wr(1); tick(); wr(10); tick(); wr(100);
        repeat (10) tick();
        chk("bp_rd_pulses", 64'(rd_cnt), 64'd2);
        chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
        chk("bp_m_data", {32'd0, m_data}, 64'd1);
        mv_cnt = 0; mv_first = -1;
        m_ready = 1'b1;
        repeat (6) tick();
        chk("bp_delivered", 64'(mv_cnt), 64'd3);
        chk("bp_no_gap", 64'(mv_last - mv_first), 64'd2);
        chk("bp_rd_total", 64'(rd_cnt), 64'd3);

        // flush
        reset_marks();
        m_ready = 1'b0;
        wr(5); tick(); wr(6); tick(); wr(7); tick(); wr(8); tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_m_valid", {63'd0, m_valid}, 64'd0);
        mv_cnt = 0;
        m_ready = 1'b1;
        repeat (8) tick();
        chk("flush_delivered", 64'(mv_cnt), 64'd2);
        chk("flush_rd_total", 64'(rd_cnt), 64'd4);

        // counter wrap
        rst = 1'b1; m_ready = 1'b0;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr(DW'(1000 + i));
            tick();
        end
        drain("wrap");
        chk("wrap_rd_count", {60'd0, rd_count}, 64'd1);

        // randomized traffic with back-pressure, flushes and one reset
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst     = (i == 700);
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) wr($urandom);
        end
        tick();
        rst = 1'b0; flush = 1'b0; m_ready = 1'b1;
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles required finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
